// File: rtl/puf_eval_if.sv
// Signal bundle between the PUF evaluation controller, the RO bank and the response FIFO.
// The master modport is the controller side; the slave modport is the side that surrounds it.
interface puf_eval_if #(
   parameter int DATA_IN_BITS   = 8,
   parameter int RESP_WORD_BITS = 8,
   parameter int RO_SEL_BITS    = 4,
   parameter int COUNT_BITS     = 16
);
   logic                      PUF_reset;
   logic                      PUF_enable;
   logic [DATA_IN_BITS-1:0]   challenge;
   logic                      PUF_done;
   logic [RO_SEL_BITS-1:0]    ro_sel_a;
   logic [RO_SEL_BITS-1:0]    ro_sel_b;
   logic                      ro_count_clr;
   logic                      ro_count_en;
   logic [COUNT_BITS-1:0]     count_a;
   logic [COUNT_BITS-1:0]     count_b;
   logic [RESP_WORD_BITS-1:0] FIFO_din;
   logic                      FIFO_we;
   logic                      full_FIFO;

   modport master (
      input  PUF_reset, PUF_enable, challenge, count_a, count_b, full_FIFO,
      output PUF_done, ro_sel_a, ro_sel_b, ro_count_clr, ro_count_en, FIFO_din, FIFO_we
   );

   modport slave (
      output PUF_reset, PUF_enable, challenge, count_a, count_b, full_FIFO,
      input  PUF_done, ro_sel_a, ro_sel_b, ro_count_clr, ro_count_en, FIFO_din, FIFO_we
   );
endinterface

// File: rtl/puf_eval_fsm.sv
// Ring-oscillator PUF evaluation controller: LFSR-driven pair selection, count compare, word packing.
// Optional feature macro: PUF_MAJORITY_VOTE_EN (3 compares per response bit, majority decides).
module puf_eval_fsm #(
   parameter int DATA_IN_BITS   = 8,
   parameter int RESP_WORD_BITS = 8,
   parameter int NUM_WORDS      = 4,
   parameter int RO_SEL_BITS    = 4,
   parameter int COUNT_BITS     = 16,
   parameter int WINDOW_CYCLES  = 1024,
   parameter int SETTLE_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   puf_eval_if.master bus,
   output logic [2:0] dbg_state
);
   localparam int BIT_W  = (RESP_WORD_BITS > 1) ? $clog2(RESP_WORD_BITS) : 1;
   localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CYC_W  = $clog2(WINDOW_CYCLES + SETTLE_CYCLES) + 1;
   localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(RESP_WORD_BITS - 1);
   localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(NUM_WORDS - 1);
   localparam logic [CYC_W-1:0]  WIN_LAST   = CYC_W'(WINDOW_CYCLES - 1);
   localparam logic [CYC_W-1:0]  SET_LAST   = CYC_W'(SETTLE_CYCLES - 1);

   // Encoding is visible on dbg_state: IDLE=0 .. DONE=6.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_COUNT   = 3'd2,
      S_SETTLE  = 3'd3,
      S_COMPARE = 3'd4,
      S_WRITE   = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t                    state_q, state_d;
   logic [CYC_W-1:0]          cyc_q;
   logic [7:0]                lfsr_q, lfsr_d, lfsr_step, seed;
   logic [BIT_W-1:0]          bit_q;
   logic [WORD_W-1:0]         word_q;
   logic [RESP_WORD_BITS-1:0] shreg_q;
   logic [RO_SEL_BITS-1:0]    sel_a_q, sel_b_q, sel_a_d, sel_b_d;
   logic                      clr_q, en_q, we_q, done_q;
   logic                      rst, cmp_bit, resp_bit, last_vote;
   logic [DATA_IN_BITS-1:0]   chal;
   logic [COUNT_BITS-1:0]     cnt_a, cnt_b;

   assign chal      = bus.challenge;
   assign cnt_a     = bus.count_a;
   assign cnt_b     = bus.count_b;
   assign rst       = reset | bus.PUF_reset;
   assign cmp_bit   = cnt_a > cnt_b;
   assign seed      = (chal[7:0] == 8'h00) ? 8'h01 : chal[7:0];
   assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);

`ifdef PUF_MAJORITY_VOTE_EN
   logic [1:0] vote_q, ones_q, ones_sum;
   assign last_vote = (vote_q == 2'd2);
   assign ones_sum  = ones_q + {1'b0, cmp_bit};
   assign resp_bit  = (ones_sum >= 2'd2);
`else
   assign last_vote = 1'b1;
   assign resp_bit  = cmp_bit;
`endif

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      case (state_q)
         S_IDLE:    if (bus.PUF_enable) begin
                       state_d = S_CLEAR;
                       lfsr_d  = seed;
                    end
         S_CLEAR:   state_d = S_COUNT;
         S_COUNT:   if (cyc_q == WIN_LAST) state_d = S_SETTLE;
         S_SETTLE:  if (cyc_q == SET_LAST) state_d = S_COMPARE;
         S_COMPARE: begin
                       state_d = (last_vote && bit_q == LAST_BIT) ? S_WRITE : S_CLEAR;
                       if (last_vote) lfsr_d = lfsr_step;
                    end
         S_WRITE:   if (we_q) state_d = (word_q == LAST_WORD) ? S_DONE : S_CLEAR;
         S_DONE:    if (!bus.PUF_enable) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // Losing enable mid-run abandons the evaluation, partial word included.
      if (!bus.PUF_enable && state_q != S_IDLE && state_q != S_DONE) state_d = S_IDLE;
   end

   always_comb begin
      sel_a_d = lfsr_d[RO_SEL_BITS-1:0];
      sel_b_d = lfsr_d[2*RO_SEL_BITS-1:RO_SEL_BITS];
      if (sel_a_d == sel_b_d) sel_b_d = sel_b_d ^ RO_SEL_BITS'(1);
   end

   // FIFO handshake: FIFO_we is launched only from an edge where full_FIFO was low, and the
   // word on FIFO_din transfers on the edge that ends the cycle in which FIFO_we is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         lfsr_q  <= '0;
         bit_q   <= '0;
         word_q  <= '0;
         shreg_q <= '0;
         sel_a_q <= '0;
         sel_b_q <= '0;
         clr_q   <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
         vote_q  <= '0;
         ones_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= (state_d == state_q) ? cyc_q + 1'b1 : '0;
         lfsr_q  <= lfsr_d;
         if (state_q == S_IDLE && bus.PUF_enable) begin
            bit_q  <= '0;
            word_q <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_q <= '0;
            ones_q <= '0;
`endif
         end
         if (state_q == S_COMPARE) begin
`ifdef PUF_MAJORITY_VOTE_EN
            vote_q <= last_vote ? 2'd0 : vote_q + 2'd1;
            ones_q <= last_vote ? 2'd0 : ones_sum;
`endif
            if (last_vote) begin
               shreg_q <= {shreg_q[RESP_WORD_BITS-2:0], resp_bit};
               bit_q   <= (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
            end
         end
         if (state_q == S_WRITE && we_q) word_q <= word_q + 1'b1;
         if (state_d == S_CLEAR) begin
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
         end
         clr_q  <= (state_d == S_CLEAR);
         en_q   <= (state_d == S_COUNT);
         we_q   <= (state_d == S_WRITE) && !bus.full_FIFO;
         done_q <= (state_d == S_DONE);
      end
   end

   assign bus.PUF_done     = done_q;
   assign bus.ro_sel_a     = sel_a_q;
   assign bus.ro_sel_b     = sel_b_q;
   assign bus.ro_count_clr = clr_q;
   assign bus.ro_count_en  = en_q;
   assign bus.FIFO_din     = shreg_q;
   assign bus.FIFO_we      = we_q;
   assign dbg_state        = state_q;
endmodule

// File: tb/tb_puf_eval_fsm.sv
// Self-checking bench for puf_eval_fsm with a small window; words are predicted by an
// LFSR/pair/compare model built directly from the evaluation rules.
module tb_puf_eval_fsm;
   localparam int WIN = 8;
   localparam int SET = 2;
   localparam int RW  = 8;
   localparam int NW  = 2;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int VOTES = 3;
`else
   localparam int VOTES = 1;
`endif
   localparam int PB     = VOTES * (1 + WIN + SET + 1);
   localparam int WORD_T = RW * PB;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] dbg_state;

   puf_eval_if #(.DATA_IN_BITS(8), .RESP_WORD_BITS(RW), .RO_SEL_BITS(4), .COUNT_BITS(16)) bus ();

   puf_eval_fsm #(
      .DATA_IN_BITS(8), .RESP_WORD_BITS(RW), .NUM_WORDS(NW), .RO_SEL_BITS(4),
      .COUNT_BITS(16), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RO counter model
   int          mode = 0;
   logic [15:0] ro_val [16];
   int          clr_n = 0;
   int          clr_base = 0;
   always_comb begin
      case (mode)
         0: begin
            bus.count_a = 16'(10 * int'(bus.ro_sel_a));
            bus.count_b = 16'(10 * int'(bus.ro_sel_b));
         end
         1: begin
            bus.count_a = 16'd500;
            bus.count_b = 16'd500;
         end
         2: begin
            bus.count_a = ro_val[bus.ro_sel_a];
            bus.count_b = ro_val[bus.ro_sel_b];
         end
         default: begin
            bus.count_a = (((clr_n - clr_base - 1) % 3) == 1) ? 16'd20 : 16'd50;
            bus.count_b = 16'd30;
         end
      endcase
   end

   // monitor
   logic [7:0] wr_q[$];
   int         wr_cyc_q[$];
   int         done_cyc_q[$];
   int         clr_cyc_q[$];
   logic [7:0] sel_q[$];
   always @(negedge clk) begin
      if (bus.FIFO_we) begin
         wr_q.push_back(bus.FIFO_din);
         wr_cyc_q.push_back(cyc);
      end
      if (bus.PUF_done) done_cyc_q.push_back(cyc);
      if (bus.ro_count_clr) begin
         clr_n <= clr_n + 1;
         clr_cyc_q.push_back(cyc);
         sel_q.push_back({bus.ro_sel_a, bus.ro_sel_b});
      end
   end

   // scoreboard
   logic [RW-1:0] exp_q[$];
   logic [7:0]    first_words [NW];
   int            n_tests = 0;
   int            n_fail = 0;

   function automatic int ro_value(input int i);
      case (mode)
         0:       return 10 * i;
         1:       return 500;
         default: return int'(ro_val[i]);
      endcase
   endfunction

   task automatic build_expected(input logic [7:0] ch);
      logic [7:0] l, w;
      int a, b;
      exp_q.delete();
      l = (ch == 8'h00) ? 8'h01 : ch;
      for (int wi = 0; wi < NW; wi++) begin
         w = 8'h00;
         for (int bi = 0; bi < RW; bi++) begin
            a = int'(l) % 16;
            b = int'(l) / 16;
            if (a == b) b = b ^ 1;
            w = {w[6:0], (ro_value(a) > ro_value(b)) ? 1'b1 : 1'b0};
            l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic clear_mon();
      wr_q.delete();
      wr_cyc_q.delete();
      done_cyc_q.delete();
      clr_cyc_q.delete();
      sel_q.delete();
   endtask

   // driver: one full evaluation, optional full_FIFO stall at the first write
   task automatic do_run(input logic [7:0] ch, input int stall, output int clr_cyc,
                         output bit timed_out, output logic [7:0] din_at_write);
      clear_mon();
      @(negedge clk);
      bus.challenge  = ch;
      bus.PUF_enable = 1'b1;
      clr_cyc        = cyc + 1;
      timed_out      = 1'b1;
      din_at_write   = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (cyc == clr_cyc + 5) bus.challenge = 8'($urandom_range(0, 255));
         if (stall > 0 && cyc == clr_cyc + WORD_T - 1) bus.full_FIFO = 1'b1;
         if (stall > 0 && cyc == clr_cyc + WORD_T - 1 + stall) bus.full_FIFO = 1'b0;
         if (cyc == clr_cyc + WORD_T) din_at_write = bus.FIFO_din;
         if (bus.PUF_done) begin
            bus.PUF_enable = 1'b0;
            timed_out = 1'b0;
            break;
         end
      end
      bus.PUF_enable = 1'b0;
      bus.full_FIFO  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.PUF_reset = 1'b0;
      bus.PUF_enable = 1'b0;
      bus.full_FIFO = 1'b0;
      bus.challenge = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
      n_tests++; if (bus.PUF_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.PUF_done); end
      n_tests++; if (bus.FIFO_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", bus.FIFO_we); end
      n_tests++; if (bus.FIFO_din !== 8'h00) begin n_fail++; $display("FAIL reset_din got %h exp 00", bus.FIFO_din); end
      n_tests++; if ({bus.ro_count_clr, bus.ro_count_en} !== 2'b00) begin n_fail++; $display("FAIL reset_ro_ctl got %b exp 00", {bus.ro_count_clr, bus.ro_count_en}); end
      n_tests++; if ({bus.ro_sel_a, bus.ro_sel_b} !== 8'h00) begin n_fail++; $display("FAIL reset_sel got %h exp 00", {bus.ro_sel_a, bus.ro_sel_b}); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_first_run();
      int c; bit to; logic [7:0] d;
      mode = 0;
      build_expected(8'h01);
      do_run(8'h01, 0, c, to, d);
      n_tests++; if (to) begin n_fail++; $display("FAIL first_timeout got timeout exp done"); end
      n_tests++; if (clr_cyc_q.size() < 1 || clr_cyc_q[0] !== c) begin n_fail++; $display("FAIL first_clear_cycle got %0d exp %0d", clr_cyc_q[0], c); end
      n_tests++; if (sel_q[0] !== 8'h10) begin n_fail++; $display("FAIL first_pair got %h exp 10", sel_q[0]); end
      n_tests++; if (sel_q[VOTES] !== 8'h8B) begin n_fail++; $display("FAIL second_pair got %h exp 8b", sel_q[VOTES]); end
      n_tests++; if (exp_q[0][7] !== 1'b1) begin n_fail++; $display("FAIL model_first_bit got %b exp 1", exp_q[0][7]); end
      n_tests++; if (wr_q.size() !== NW) begin n_fail++; $display("FAIL first_write_count got %0d exp %0d", wr_q.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         n_tests++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL first_word%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
         first_words[i] = wr_q[i];
      end
      n_tests++; if (wr_cyc_q[0] !== c + WORD_T) begin n_fail++; $display("FAIL first_w0_cycle got %0d exp %0d", wr_cyc_q[0], c + WORD_T); end
      n_tests++; if (wr_cyc_q[1] !== c + 2 * WORD_T + 1) begin n_fail++; $display("FAIL first_w1_cycle got %0d exp %0d", wr_cyc_q[1], c + 2 * WORD_T + 1); end
      n_tests++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== wr_cyc_q[1] + 1) begin n_fail++; $display("FAIL first_done got n=%0d at %0d exp 1 at %0d", done_cyc_q.size(), done_cyc_q[0], wr_cyc_q[1] + 1); end
      n_tests++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL first_back_idle got %0d exp 0", dbg_state); end
   endtask

   task automatic test_zero_seed();
      int c; bit to; logic [7:0] d;
      mode = 0;
      build_expected(8'h00);
      do_run(8'h00, 0, c, to, d);
      n_tests++; if (to || wr_q.size() !== NW) begin n_fail++; $display("FAIL zero_writes got %0d exp %0d", wr_q.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         n_tests++; if (wr_q[i] !== first_words[i] || wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_word%0d got %h exp %h", i, wr_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_tie();
      int c; bit to; logic [7:0] d;
      mode = 1;
      do_run(8'($urandom_range(1, 255)), 0, c, to, d);
      n_tests++; if (to || wr_q.size() !== NW) begin n_fail++; $display("FAIL tie_writes got %0d exp %0d", wr_q.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         n_tests++; if (wr_q[i] !== 8'h00) begin n_fail++; $display("FAIL tie_word%0d got %h exp 00", i, wr_q[i]); end
      end
   endtask

   task automatic test_full_stall();
      int c; bit to; logic [7:0] d;
      mode = 0;
      build_expected(8'h01);
      do_run(8'h01, 20, c, to, d);
      n_tests++; if (to || wr_q.size() !== NW) begin n_fail++; $display("FAIL stall_writes got %0d exp %0d", wr_q.size(), NW); end
      n_tests++; if (wr_cyc_q[0] !== c + WORD_T + 20) begin n_fail++; $display("FAIL stall_w0_cycle got %0d exp %0d", wr_cyc_q[0], c + WORD_T + 20); end
      n_tests++; if (d !== exp_q[0] || wr_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL stall_din got %h/%h exp %h", d, wr_q[0], exp_q[0]); end
      n_tests++; if (wr_cyc_q[1] !== c + 2 * WORD_T + 21) begin n_fail++; $display("FAIL stall_w1_cycle got %0d exp %0d", wr_cyc_q[1], c + 2 * WORD_T + 21); end
      n_tests++; if (wr_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL stall_w1 got %h exp %h", wr_q[1], exp_q[1]); end
      n_tests++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== c + 2 * WORD_T + 22) begin n_fail++; $display("FAIL stall_done got %0d exp %0d", done_cyc_q[0], c + 2 * WORD_T + 22); end
   endtask

   task automatic test_abort();
      int c; bit to; logic [7:0] d;
      mode = 0;
      clear_mon();
      @(negedge clk);
      bus.challenge  = 8'h01;
      bus.PUF_enable = 1'b1;
      c = cyc + 1;
      repeat (3 * PB + 5) @(negedge clk);
      n_tests++; if (bus.ro_count_en !== 1'b1) begin n_fail++; $display("FAIL abort_in_count got en=%b exp 1", bus.ro_count_en); end
      bus.PUF_enable = 1'b0;
      @(negedge clk);
      n_tests++; if (dbg_state !== 3'd0 || bus.ro_count_en !== 1'b0) begin n_fail++; $display("FAIL abort_idle got state=%0d en=%b exp 0/0", dbg_state, bus.ro_count_en); end
      repeat (300) @(negedge clk);
      n_tests++; if (wr_q.size() !== 0 || done_cyc_q.size() !== 0) begin n_fail++; $display("FAIL abort_quiet got we=%0d done=%0d exp 0/0", wr_q.size(), done_cyc_q.size()); end
      do_run(8'h01, 0, c, to, d);
      n_tests++; if (to || wr_q.size() !== NW) begin n_fail++; $display("FAIL restart_writes got %0d exp %0d", wr_q.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         n_tests++; if (wr_q[i] !== first_words[i]) begin n_fail++; $display("FAIL restart_word%0d got %h exp %h", i, wr_q[i], first_words[i]); end
      end
      n_tests++; if (wr_cyc_q[1] !== c + 2 * WORD_T + 1) begin n_fail++; $display("FAIL restart_w1_cycle got %0d exp %0d", wr_cyc_q[1], c + 2 * WORD_T + 1); end
   endtask

   task automatic test_puf_reset();
      @(negedge clk);
      bus.challenge  = 8'h5A;
      bus.PUF_enable = 1'b1;
      repeat (PB + 6) @(negedge clk);
      bus.PUF_reset = 1'b1;
      @(negedge clk);
      n_tests++; if (dbg_state !== 3'd0 || bus.ro_count_en !== 1'b0) begin n_fail++; $display("FAIL pufreset_state got %0d en=%b exp 0/0", dbg_state, bus.ro_count_en); end
      n_tests++; if ({bus.ro_sel_a, bus.ro_sel_b, bus.FIFO_din} !== 16'h0000) begin n_fail++; $display("FAIL pufreset_outs got %h exp 0000", {bus.ro_sel_a, bus.ro_sel_b, bus.FIFO_din}); end
      bus.PUF_reset  = 1'b0;
      bus.PUF_enable = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int c; bit to; logic [7:0] d, ch;
      mode = 2;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++) ro_val[i] = 16'($urandom_range(0, 7) * 100);
         ch = 8'($urandom_range(0, 255));
         build_expected(ch);
         do_run(ch, 0, c, to, d);
         n_tests++; if (to || wr_q.size() !== NW) begin n_fail++; $display("FAIL rand%0d_writes got %0d exp %0d", r, wr_q.size(), NW); end
         for (int i = 0; i < NW; i++) begin
            n_tests++; if (wr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_word%0d ch=%h got %h exp %h", r, i, ch, wr_q[i], exp_q[i]); end
         end
      end
   endtask

`ifdef PUF_MAJORITY_VOTE_EN
   task automatic test_majority();
      int c; bit to; logic [7:0] d;
      clr_base = clr_n;
      mode = 3;
      do_run(8'($urandom_range(1, 255)), 0, c, to, d);
      n_tests++; if (to || wr_q.size() !== NW) begin n_fail++; $display("FAIL maj_writes got %0d exp %0d", wr_q.size(), NW); end
      for (int i = 0; i < NW; i++) begin
         n_tests++; if (wr_q[i] !== 8'hFF) begin n_fail++; $display("FAIL maj_word%0d got %h exp ff", i, wr_q[i]); end
      end
      n_tests++; if (clr_cyc_q[3] - clr_cyc_q[0] !== 36) begin n_fail++; $display("FAIL maj_bit_time got %0d exp 36", clr_cyc_q[3] - clr_cyc_q[0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_first_run();
      test_zero_seed();
      test_tie();
      test_full_stall();
      test_abort();
      test_puf_reset();
      test_random();
`ifdef PUF_MAJORITY_VOTE_EN
      test_majority();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
